dice_roller_core: RTL

Parametrised dice engine for the TinyTapeout dice project. It takes NUM_DICE raw push-buttons, each bound to a die with a BCD face count. Each button is debounced, and the block spins a BCD value cyclically from the face count down to 1 while that button is held. On release it latches the result. It also drives a time-multiplexed NUM_DIGITS seven-segment display with leading-zero blanking and selectable polarity.

---
 rtl/dice_roller_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dice_roller_core.sv
// Dice engine: debounced buttons spin a BCD die value while held, latch it on release, and scan a 7-seg display.
// seg/dig/result/result_valid registered (1 clk); free-running with no backpressure, buttons are never stalled.
module dice_roller_core #(
  parameter int NUM_DICE = 7,
  parameter int NUM_DIGITS = 3,
  parameter logic [4*NUM_DIGITS*NUM_DICE-1:0] DIE_FACES =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004},
  parameter int PRESCALE_BITS = 10,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DICE-1:0]     btn,
  input  logic                    invert_seg,
  input  logic                    invert_dig,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [4*NUM_DIGITS-1:0] result,
  output logic                    result_valid,
  output logic                    rolling
);
  localparam int RW = 4*NUM_DIGITS;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int IW = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam logic [RW-1:0] ONE = RW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ROLLING = 2'd1, HOLD = 2'd2} state_t;

  logic [PRESCALE_BITS-1:0] presc;
  logic                     tick;
  logic [NUM_DICE-1:0]      sync1, sync2, deb;
  logic [3:0]               db_cnt [NUM_DICE];
  logic [IW-1:0]            low_idx, sel;
  logic [RW-1:0]            value;
  state_t                   state, state_nxt;
  logic [SW-1:0]            scan;
  logic [NUM_DIGITS-1:0]    blank;
  logic                     nz_above;
  logic [3:0]               cur_digit;
  logic [6:0]               seg7;
  logic [7:0]               seg_raw;
  logic [NUM_DIGITS-1:0]    dig_raw;

  function automatic logic [RW-1:0] face_of(input logic [IW-1:0] idx);
    return DIE_FACES[int'(idx)*RW +: RW];
  endfunction

  // Decimal decrement: a zero digit borrows and becomes 9.
  function automatic logic [RW-1:0] bcd_dec(input logic [RW-1:0] v);
    logic       borrow;
    logic [3:0] d;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = v[4*k +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          bcd_dec[4*k +: 4] = 4'd9;
        end else begin
          bcd_dec[4*k +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + 1'b1;
  end
  assign tick = (presc == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NUM_DICE; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (tick) begin
        for (int i = 0; i < NUM_DICE; i++) begin
          if (sync2[i] == deb[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == 4'(DEBOUNCE_TICKS - 1)) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_DICE-1; i >= 0; i--) begin
      if (deb[i]) low_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // HOLD waits for every button to go low so a second held button cannot re-roll.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|deb)      state_nxt = ROLLING;
      ROLLING: if (!deb[sel]) state_nxt = HOLD;
      HOLD:    if (!(|deb))   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rolling = (state == ROLLING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel          <= '0;
      value        <= ONE;
      result       <= ONE;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|deb) begin
            sel   <= low_idx;
            value <= face_of(low_idx);
          end
        end
        ROLLING: begin
          value <= (value == ONE) ? face_of(sel) : bcd_dec(value);
          if (!deb[sel]) begin
            result       <= value;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                             scan <= '0;
    else if (scan == SW'(NUM_DIGITS - 1))   scan <= '0;
    else                                    scan <= scan + 1'b1;
  end

  // A digit is blank when it and everything above it is zero; units always shows.
  always_comb begin
    nz_above = 1'b0;
    blank    = '0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      nz_above = nz_above | (result[4*k +: 4] != 4'd0);
      blank[k] = (k != 0) && !nz_above;
    end
  end

  always_comb begin
    cur_digit = result[int'(scan)*4 +: 4];
    case (cur_digit)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
    seg_raw = {1'b0, seg7};
    dig_raw = NUM_DIGITS'(1) << scan;
    if (rolling || blank[scan]) begin
      seg_raw = '0;
      dig_raw = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= '0;
      dig <= '0;
    end else begin
      seg <= seg_raw ^ {8{invert_seg}};
      dig <= dig_raw ^ {NUM_DIGITS{invert_dig}};
    end
  end

endmodule
